// File: rtl/pipeline_ctrl.sv
// Central hazard/forwarding control for the 5-stage core: shadows EXE/MEM/WB control fields and
// produces stall, flush, memory-wait freeze and per-source forwarding selects, all combinational.
module pipeline_ctrl #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 3,
  parameter int FWD_EN   = 1,
  parameter int MEM_WAIT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_dest,
  input  logic                        id_wb_en,
  input  logic                        id_mem_read,
  input  logic                        id_mem_write,
  input  logic                        exe_br_taken,
  output logic                        stall,
  output logic                        flush,
  output logic                        freeze,
  output logic [2*NUM_SRC-1:0]        fwd_sel
);

  logic                       r_exe_vld, r_exe_wb_en, r_exe_mem_read, r_exe_mem_op;
  logic [REG_AW-1:0]          r_exe_dest;
  logic [NUM_SRC*REG_AW-1:0]  r_exe_src;
  logic [NUM_SRC-1:0]         r_exe_src_used;

  logic                       r_mem_vld, r_mem_wb_en, r_mem_mem_read, r_mem_mem_op;
  logic [REG_AW-1:0]          r_mem_dest;

  logic                       r_wb_vld, r_wb_wb_en;
  logic [REG_AW-1:0]          r_wb_dest;

  logic [NUM_SRC-1:0]         w_hit_exe, w_hit_mem;
  logic                       w_stall_raw, w_freeze, w_flush, w_stall;
  logic [2*NUM_SRC-1:0]       w_fwd;

  always_comb begin
    w_hit_exe = '0;
    w_hit_mem = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_hit_exe[k] = id_valid & id_src_used[k] & r_exe_vld & r_exe_wb_en &
                     (id_src[k*REG_AW +: REG_AW] == r_exe_dest);
      w_hit_mem[k] = id_valid & id_src_used[k] & r_mem_vld & r_mem_wb_en &
                     (id_src[k*REG_AW +: REG_AW] == r_mem_dest);
    end
  end

  // With forwarding only a load in EXE cannot supply its result in time.
  assign w_stall_raw = (FWD_EN != 0) ? ((|w_hit_exe) & r_exe_mem_read)
                                     : (|(w_hit_exe | w_hit_mem));

  always_comb begin
    w_fwd = '0;
    if (FWD_EN != 0) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (r_exe_vld & r_exe_src_used[k]) begin
          if (r_mem_vld & r_mem_wb_en & ~r_mem_mem_read &
              (r_mem_dest == r_exe_src[k*REG_AW +: REG_AW]))
            w_fwd[2*k +: 2] = 2'd1;
          else if (r_wb_vld & r_wb_wb_en & (r_wb_dest == r_exe_src[k*REG_AW +: REG_AW]))
            w_fwd[2*k +: 2] = 2'd2;
        end
      end
    end
  end

  generate
    if (MEM_WAIT > 0) begin : g_wait
      localparam int CW = $clog2(MEM_WAIT + 1);
      logic [CW-1:0] r_cnt;

      assign w_freeze = r_mem_vld & r_mem_mem_op & (r_cnt != CW'(MEM_WAIT));

      // Counter returns to zero on the release edge so the next memory op waits in full.
      always_ff @(posedge clk) begin
        if (rst)           r_cnt <= '0;
        else if (w_freeze) r_cnt <= r_cnt + CW'(1);
        else               r_cnt <= '0;
      end
    end else begin : g_nowait
      logic w_unused_mem_op;
      assign w_unused_mem_op = r_mem_mem_op;
      assign w_freeze = 1'b0;
    end
  endgenerate

  assign w_flush = exe_br_taken & ~w_freeze;
  assign w_stall = w_stall_raw & ~w_flush;

  assign stall   = w_stall;
  assign flush   = w_flush;
  assign freeze  = w_freeze;
  assign fwd_sel = w_fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe_vld      <= 1'b0;
      r_exe_wb_en    <= 1'b0;
      r_exe_mem_read <= 1'b0;
      r_exe_mem_op   <= 1'b0;
      r_mem_vld      <= 1'b0;
      r_mem_wb_en    <= 1'b0;
      r_mem_mem_read <= 1'b0;
      r_mem_mem_op   <= 1'b0;
      r_wb_vld       <= 1'b0;
      r_wb_wb_en     <= 1'b0;
    end else if (!w_freeze) begin
      r_wb_vld       <= r_mem_vld;
      r_wb_wb_en     <= r_mem_wb_en;
      r_wb_dest      <= r_mem_dest;

      r_mem_vld      <= r_exe_vld;
      r_mem_wb_en    <= r_exe_wb_en;
      r_mem_mem_read <= r_exe_mem_read;
      r_mem_mem_op   <= r_exe_mem_op;
      r_mem_dest     <= r_exe_dest;

      if (w_stall | w_flush) begin
        r_exe_vld      <= 1'b0;
      end else begin
        r_exe_vld      <= id_valid;
        r_exe_wb_en    <= id_wb_en;
        r_exe_mem_read <= id_mem_read;
        r_exe_mem_op   <= id_mem_read | id_mem_write;
        r_exe_dest     <= id_dest;
        r_exe_src      <= id_src;
        r_exe_src_used <= id_src_used;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised + directed bench for pipeline_ctrl: three configurations (forwarding, no forwarding,
// forwarding with a 3-cycle memory wait) checked every cycle against an instruction-level model.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic            v;
    logic [3:0]      dest;
    logic            wb;
    logic            ld;
    logic            st;
    logic [2:0][3:0] src;
    logic [2:0]      used;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, id_wb_en, id_mem_read, id_mem_write, exe_br_taken;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic [3:0]  id_dest;

  logic       o_stall[3], o_flush[3], o_freeze[3];
  logic [5:0] o_fwd[3];

  pipeline_ctrl #(.REG_AW(4), .NUM_SRC(3), .FWD_EN(1), .MEM_WAIT(0)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exe_br_taken(exe_br_taken), .stall(o_stall[0]), .flush(o_flush[0]), .freeze(o_freeze[0]),
    .fwd_sel(o_fwd[0]));

  pipeline_ctrl #(.REG_AW(4), .NUM_SRC(3), .FWD_EN(0), .MEM_WAIT(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exe_br_taken(exe_br_taken), .stall(o_stall[1]), .flush(o_flush[1]), .freeze(o_freeze[1]),
    .fwd_sel(o_fwd[1]));

  pipeline_ctrl #(.REG_AW(4), .NUM_SRC(3), .FWD_EN(1), .MEM_WAIT(3)) u_wait (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exe_br_taken(exe_br_taken), .stall(o_stall[2]), .flush(o_flush[2]), .freeze(o_freeze[2]),
    .fwd_sel(o_fwd[2]));

  int cfg_fwd[3] = '{1, 0, 1};
  int cfg_mw[3]  = '{0, 0, 3};

  // Model: the instructions sitting in EXE/MEM/WB (index 0/1/2) and cycles of wait still owed.
  ins_t ms[3][3];
  int   rem[3];

  logic       s_stall[3], s_flush[3], s_freeze[3];
  logic [5:0] s_fwd[3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic v, input logic [3:0] d, input logic wb, input logic ld,
                              input logic st, input logic [3:0] s0, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [2:0] used);
    ins_t t;
    t.v = v; t.dest = d; t.wb = wb; t.ld = ld; t.st = st;
    t.src[0] = s0; t.src[1] = s1; t.src[2] = s2; t.used = used;
    return t;
  endfunction

  task automatic model_eval(input int c, input ins_t id, input logic br, output logic e_stall,
                            output logic e_flush, output logic e_freeze, output logic [5:0] e_fwd);
    ins_t ex, me, wb;
    logic raw_ld, raw_any;
    ex = ms[c][0]; me = ms[c][1]; wb = ms[c][2];
    raw_ld = 1'b0; raw_any = 1'b0;
    e_freeze = (cfg_mw[c] > 0) && me.v && (me.ld || me.st) && (rem[c] > 0);
    for (int k = 0; k < 3; k++) begin
      if (id.v && id.used[k]) begin
        if (ex.v && ex.wb && id.src[k] == ex.dest) begin
          raw_any = 1'b1;
          if (ex.ld) raw_ld = 1'b1;
        end
        if (me.v && me.wb && id.src[k] == me.dest) raw_any = 1'b1;
      end
    end
    e_flush = br && !e_freeze;
    e_stall = ((cfg_fwd[c] != 0) ? raw_ld : raw_any) && !e_flush;
    e_fwd = '0;
    if (cfg_fwd[c] != 0) begin
      for (int k = 0; k < 3; k++) begin
        if (ex.v && ex.used[k]) begin
          if (me.v && me.wb && !me.ld && me.dest == ex.src[k]) e_fwd[2*k +: 2] = 2'd1;
          else if (wb.v && wb.wb && wb.dest == ex.src[k])     e_fwd[2*k +: 2] = 2'd2;
        end
      end
    end
  endtask

  task automatic step(input ins_t id, input logic br, input logic r, input bit cmp);
    logic e_stall, e_flush, e_freeze;
    logic [5:0] e_fwd;
    rst = r; exe_br_taken = br;
    id_valid = id.v; id_src = id.src; id_src_used = id.used; id_dest = id.dest;
    id_wb_en = id.wb; id_mem_read = id.ld; id_mem_write = id.st;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      s_stall[c] = o_stall[c]; s_flush[c] = o_flush[c];
      s_freeze[c] = o_freeze[c]; s_fwd[c] = o_fwd[c];
      model_eval(c, id, br, e_stall, e_flush, e_freeze, e_fwd);
      if (cmp) begin
        check($sformatf("stall[%0d]", c),  32'(s_stall[c]),  32'(e_stall));
        check($sformatf("flush[%0d]", c),  32'(s_flush[c]),  32'(e_flush));
        check($sformatf("freeze[%0d]", c), 32'(s_freeze[c]), 32'(e_freeze));
        check($sformatf("fwd_sel[%0d]", c), 32'(s_fwd[c]),   32'(e_fwd));
      end
      if (r) begin
        for (int s = 0; s < 3; s++) ms[c][s] = '0;
        rem[c] = 0;
      end else if (e_freeze) begin
        rem[c]--;
      end else begin
        ms[c][2] = ms[c][1];
        ms[c][1] = ms[c][0];
        ms[c][0] = (e_stall || e_flush) ? '0 : id;
        if (ms[c][1].ld || ms[c][1].st) rem[c] = cfg_mw[c];
      end
    end
    @(posedge clk);
    #1;
  endtask

  ins_t nop, add1, add1b, sub, ldr, add5, str, rnd;
  int cnt_a, cnt_b;

  initial begin
    nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    add1  = mk(1, 1, 1, 0, 0, 7, 8, 0, 3'b011);
    add1b = mk(1, 1, 1, 0, 0, 9, 9, 0, 3'b011);
    sub   = mk(1, 2, 1, 0, 0, 1, 3, 0, 3'b011);
    ldr   = mk(1, 4, 1, 1, 0, 6, 0, 0, 3'b001);
    add5  = mk(1, 5, 1, 0, 0, 4, 4, 0, 3'b011);
    str   = mk(1, 0, 0, 0, 1, 2, 3, 6, 3'b111);
    for (int c = 0; c < 3; c++) begin
      rem[c] = 0;
      for (int s = 0; s < 3; s++) ms[c][s] = '0;
    end

    // Reset: every output of every configuration idle.
    step(nop, 0, 1, 0);
    step(nop, 0, 0, 1);
    for (int c = 0; c < 3; c++)
      check($sformatf("reset_outs[%0d]", c),
            {26'd0, s_stall[c], s_flush[c], s_freeze[c], s_fwd[c] != 6'd0}, 32'd0);

    // ADD r1 ; SUB r2,r1,r3: forwarded from MEM, no stall with forwarding.
    step(add1, 0, 0, 1);
    step(sub, 0, 0, 1);
    check("add_sub_no_stall", 32'(s_stall[0]), 32'd0);
    step(nop, 0, 0, 1);
    check("add_sub_fwd_mem", 32'(s_fwd[0][1:0]), 32'd1);

    // Without forwarding the SUB waits two cycles and nothing is forwarded.
    repeat (3) step(nop, 0, 0, 1);
    step(add1, 0, 0, 1);
    cnt_a = 0; cnt_b = 0;
    repeat (3) begin
      step(sub, 0, 0, 1);
      cnt_a += int'(s_stall[1]);
      cnt_b += int'(s_fwd[1] != 6'd0);
    end
    check("nofwd_stall_cycles", 32'(cnt_a), 32'd2);
    check("nofwd_fwd_zero", 32'(cnt_b), 32'd0);

    // WB forward, then MEM beating WB on the same register.
    repeat (3) step(nop, 0, 0, 1);
    step(add1, 0, 0, 1);
    step(nop, 0, 0, 1);
    step(sub, 0, 0, 1);
    step(nop, 0, 0, 1);
    check("fwd_from_wb", 32'(s_fwd[0][1:0]), 32'd2);
    step(add1, 0, 0, 1);
    step(add1b, 0, 0, 1);
    step(sub, 0, 0, 1);
    step(nop, 0, 0, 1);
    check("mem_over_wb", 32'(s_fwd[0][1:0]), 32'd1);

    // Load-use: one stall cycle, then both sources take the WB value.
    repeat (3) step(nop, 0, 0, 1);
    step(ldr, 0, 0, 1);
    step(add5, 0, 0, 1);
    check("load_use_stall", 32'(s_stall[0]), 32'd1);
    step(add5, 0, 0, 1);
    check("load_use_release", 32'(s_stall[0]), 32'd0);
    step(nop, 0, 0, 1);
    check("load_use_fwd_wb", 32'(s_fwd[0][3:0]), 32'hA);

    // Store with 3-cycle wait; a branch held across the freeze flushes once, on release.
    repeat (3) step(nop, 0, 0, 1);
    step(str, 0, 0, 1);
    step(nop, 0, 0, 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      step(nop, 1, 0, 1);
      cnt_a += int'(s_freeze[2]);
      cnt_b += int'(s_flush[2]);
    end
    check("freeze_cycles", 32'(cnt_a), 32'd3);
    check("flush_once", 32'(cnt_b), 32'd1);
    check("flush_on_release", 32'(s_flush[2]), 32'd1);
    step(nop, 0, 0, 1);
    check("freeze_after_release", 32'(s_freeze[2]), 32'd0);

    // Reset while the wait counter is at 1.
    repeat (3) step(nop, 0, 0, 1);
    step(str, 0, 0, 1);
    step(nop, 0, 0, 1);
    step(nop, 0, 0, 1);
    step(nop, 0, 1, 1);
    check("freeze_before_rst", 32'(s_freeze[2]), 32'd1);
    step(nop, 0, 0, 1);
    check("rst_mid_freeze",
          {26'd0, s_stall[2], s_flush[2], s_freeze[2], s_fwd[2] != 6'd0}, 32'd0);

    // Random traffic over a small register set to provoke many hazards.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      rnd = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)),
               kind <= 1, kind == 1, kind == 2,
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)));
      step(rnd, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Centralised pipeline control for the 5-stage ARM core (IF/ID/EXE/MEM/WB).
- Replaces the separate hazard-detection and forwarding units with one parametrised block.
- Keeps shadow copies of the EXE/MEM/WB control fields and generates stall, flush, freeze and per-source forwarding selects.
- Adds what the two-unit scheme lacks: N source operands, a compile-time forwarding on/off mode, and a multi-cycle memory wait freeze.

Parameters:
REG_AW, 4, register address width
NUM_SRC, 3, source operands per instruction (Rn, Rm, Rd-as-store-data)
FWD_EN, 1, 1 = forwarding with load-use stall only; 0 = stall on any RAW against EXE/MEM
MEM_WAIT, 0, extra cycles a load/store holds the MEM stage (0 = single-cycle memory)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_src  in  NUM_SRC*REG_AW  ID source register numbers, src k at bits [k*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  per-source "operand actually read" flag
id_dest  in  REG_AW  ID destination register
id_wb_en  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
id_mem_write  in  1  ID instruction is a store
exe_br_taken  in  1  branch resolved taken in EXE this cycle
stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE
flush  out  1  squash IF/ID and ID/EXE contents
freeze  out  1  hold every pipeline register (memory wait)
fwd_sel  out  2*NUM_SRC  per EXE source: 0 = regfile, 1 = MEM-stage ALU result, 2 = WB value

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Shadow state, per stage (EXE, MEM, WB):
  - fields: valid, dest, wb_en, mem_read, mem_op;
  - the EXE shadow also stores src[] and src_used[].
- Shadow advance (posedge):
  - Nothing moves when freeze=1.
  - Otherwise WB<=MEM and MEM<=EXE.
  - EXE<=ID fields when stall=0 and flush=0; otherwise EXE<=bubble (valid=0).
- Reset:
  - All shadow valid bits, wb_en, mem_read and mem_op clear; wait counter = 0.
  - All outputs 0 in the cycle after rst is sampled high.
  - Reset mid-freeze aborts the wait; freeze=0 on the next cycle.
- Match definition: id source k matches stage S when id_valid & id_src_used[k] & S.valid & S.wb_en & (id_src[k]==S.dest).
- Stall (combinational):
  - FWD_EN=1: stall = any k match EXE with EXE.mem_read (load-use).
  - FWD_EN=0: stall = any k match EXE or MEM.
  - WB matches never stall; the regfile writes before it is read within a cycle.
- Forwarding (combinational, FWD_EN=1 only; all zeros when FWD_EN=0):
  - For each EXE source k with EXE.valid & src_used[k]:
    - sel=1 if MEM.valid & MEM.wb_en & !MEM.mem_read & MEM.dest==src;
    - else sel=2 if WB.valid & WB.wb_en & WB.dest==src;
    - else 0.
  - MEM has priority over WB.
  - A load in MEM never forwards; load-use is covered by the stall.
- Flush:
  - flush = exe_br_taken & !freeze.
  - flush overrides stall: stall is forced to 0 whenever flush=1.
  - A branch seen during freeze takes effect in the first unfrozen cycle (exe_br_taken is held by the frozen EXE stage).
- Memory wait (MEM_WAIT>0):
  - Counter width = clog2(MEM_WAIT+1).
  - freeze = MEM.valid & MEM.mem_op & (cnt != MEM_WAIT).
  - While freeze=1: cnt increments each cycle.
  - When cnt==MEM_WAIT: freeze drops, the pipeline advances, and cnt returns to 0 on that edge.
  - Back-to-back memory ops each wait the full MEM_WAIT cycles.
  - MEM_WAIT=0: freeze is tied to 0.
- Priority: rst > freeze > flush > stall.
  - During freeze, stall and fwd_sel keep their combinational values but have no effect.
- Latency: all outputs are combinational from the shadow registers and the ID inputs; the block adds no pipeline cycles.

Test Plan:
- ADD r1 at cycle 0, SUB r2,r1,r3 next (FWD_EN=1) -> stall=0; when SUB is in EXE, fwd_sel[src0]=1.
- ADD r1; NOP; SUB using r1 -> fwd_sel=2; with a MEM match also present on the same register, sel=1 wins.
- LDR r4 followed directly by ADD r5,r4,r4 -> stall=1 for exactly 1 cycle, EXE gets a bubble; next cycle both ADD sources show fwd_sel=2.
- FWD_EN=0, ADD r1 then SUB using r1 -> stall=1 for 2 cycles; fwd_sel stays 0.
- MEM_WAIT=3, STR reaches MEM -> freeze=1 for 3 cycles then 0; a branch resolved in EXE during the freeze flushes exactly once, on the release cycle.
- rst asserted mid-freeze (cnt=1) -> next cycle freeze=stall=flush=0, fwd_sel=0, all shadows invalid.
